// File: rtl/scan_pkg.sv
// Shared types and {Test,Load} mode encodings for the scan-chain sequencer.
package scan_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_IN,
    CAPTURE,
    SHIFT_OUT,
    DONE
  } scan_state_t;

  localparam logic [1:0] HOLD  = 2'b00;
  localparam logic [1:0] CAPT  = 2'b01;
  localparam logic [1:0] SHIFT = 2'b10;

endpackage

// File: rtl/scan_shreg.sv
// Parallel-load, right-shift register; serial input enters at the MSB and the serial output is o_q[0].
module scan_shreg #(
  parameter int CHAIN_LEN = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_load,
  input  logic [CHAIN_LEN-1:0] i_load_val,
  input  logic                 i_shift,
  input  logic                 i_sin,
  output logic [CHAIN_LEN-1:0] o_q
);

  logic [CHAIN_LEN-1:0] r_q;

  // Load has priority over shift so a new sequence always starts from a clean pattern.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_load_val;
    end else if (i_shift) begin
      r_q <= {i_sin, r_q[CHAIN_LEN-1:1]};
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/scan_chain_ctrl.sv
// Scan-chain sequencer: shift pattern in, one capture cycle, shift result out.
// Optional SCAN_CHAIN_CTRL_COMPARE_EN adds i_expected/o_fail result comparison.
module scan_chain_ctrl #(
  parameter int CHAIN_LEN = 8
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [CHAIN_LEN-1:0] i_pattern,
  input  logic                 i_sdo,
  output logic                 o_test,
  output logic                 o_load,
  output logic                 o_sdi,
  output logic [CHAIN_LEN-1:0] o_result,
  output logic                 o_busy,
`ifdef SCAN_CHAIN_CTRL_COMPARE_EN
  output logic                 o_done,
  input  logic [CHAIN_LEN-1:0] i_expected,
  output logic                 o_fail
`else
  output logic                 o_done
`endif
);
  import scan_pkg::*;

  localparam int             CW   = $clog2(CHAIN_LEN + 1);
  localparam logic [CW-1:0]  LAST = CW'(CHAIN_LEN - 1);

  scan_state_t          r_state;
  scan_state_t          w_state_next;
  logic [CW-1:0]        r_cnt;
  logic [1:0]           w_mode;
  logic                 w_accept;
  logic [CHAIN_LEN-1:0] w_pat_q;
  logic                 w_unused_pat_hi;

  assign w_accept = (r_state == IDLE) && i_start;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        SHIFT_IN, SHIFT_OUT: r_cnt <= r_cnt + 1'b1;
        default:             r_cnt <= '0;
      endcase
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:      if (i_start)        w_state_next = SHIFT_IN;
      SHIFT_IN:  if (r_cnt == LAST)  w_state_next = CAPTURE;
      CAPTURE:                       w_state_next = SHIFT_OUT;
      SHIFT_OUT: if (r_cnt == LAST)  w_state_next = DONE;
      DONE:                          w_state_next = IDLE;
      default:                       w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_mode = HOLD;
    o_busy = 1'b1;
    o_done = 1'b0;
    case (r_state)
      IDLE:                w_mode = HOLD;
      SHIFT_IN, SHIFT_OUT: w_mode = SHIFT;
      CAPTURE:             w_mode = CAPT;
      DONE:                o_done = 1'b1;
      default:             w_mode = HOLD;
    endcase
    if (r_state == IDLE) o_busy = 1'b0;
  end

  assign o_test = w_mode[1];
  assign o_load = w_mode[0];

  scan_shreg #(.CHAIN_LEN(CHAIN_LEN)) u_pat_shreg (
    .i_clk      (i_clock),
    .i_rst      (i_reset),
    .i_load     (w_accept),
    .i_load_val (i_pattern),
    .i_shift    (r_state == SHIFT_IN),
    .i_sin      (1'b0),
    .o_q        (w_pat_q)
  );

  // Only the LSB feeds the chain; the upper bits are internal shift storage.
  assign w_unused_pat_hi = ^w_pat_q[CHAIN_LEN-1:1];
  assign o_sdi           = (r_state == SHIFT_IN) && w_pat_q[0];

  scan_shreg #(.CHAIN_LEN(CHAIN_LEN)) u_res_shreg (
    .i_clk      (i_clock),
    .i_rst      (i_reset),
    .i_load     (1'b0),
    .i_load_val ('0),
    .i_shift    (r_state == SHIFT_OUT),
    .i_sin      (i_sdo),
    .o_q        (o_result)
  );

`ifdef SCAN_CHAIN_CTRL_COMPARE_EN
  logic [CHAIN_LEN-1:0] r_expected;
  logic                 r_fail;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_expected <= '0;
      r_fail     <= 1'b0;
    end else begin
      if (w_accept)          r_expected <= i_expected;
      if (r_state == DONE)   r_fail     <= |(o_result ^ r_expected);
    end
  end

  assign o_fail = r_fail;
`endif

endmodule
